uart_rx_fsm: RTL and testbench

Frame-sequencing controller for the UART receiver. It detects the start-bit falling edge on RX_IN and runs the oversampling edge/bit counters. It issues one-cycle enables to the sampler, deserializer, start/parity/stop checkers, then qualifies the received byte with a single-cycle data_valid. It sits between the RX pin synchronizer and the RX datapath blocks and is their only source of enables.

---
 rtl/uart_rx_fsm.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
//
// Frame-sequencing controller for the UART receiver. Detects the start-bit
// falling edge on RX_IN, runs the oversampling edge counter and the data bit
// counter, and issues one-cycle enables to the sampler, deserializer and the
// start/parity/stop checkers. A good frame is qualified by a one-cycle
// data_valid pulse in the first IDLE cycle after the stop bit.
//
// Parameters:
//   DATA_WIDTH   data bits per frame
//   PRESCALE_W   width of Prescale and of the internal edge counter
//
// Ports:
//   CLK          oversampling clock
//   RST          asynchronous active-high reset
//   RX_IN        synchronized serial line, idle high
//   Prescale     oversampling ratio (8, 16 or 32)
//   PAR_EN       parity bit present (latched at frame start)
//   strt_glitch  start checker result, 1 = glitch
//   par_err      parity checker result
//   stp_err      stop checker result
//   dat_samp_en  sampler enable, high in every non-IDLE state
//   strt_chk_en  one-cycle start-check strobe
//   deser_en     one-cycle shift strobe per data bit
//   par_chk_en   one-cycle parity-check strobe
//   stp_chk_en   one-cycle stop-check strobe
//   data_valid   one-cycle frame-good pulse
//   frame_err    one-cycle frame-rejected pulse (only with UART_RX_ERR_OUT_EN)
//
// Build option:
//   UART_RX_ERR_OUT_EN  adds the frame_err output.
// ---------------------------------------------------------------------------
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  dat_samp_en,
    output logic                  strt_chk_en,
    output logic                  deser_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid
`ifdef UART_RX_ERR_OUT_EN
    ,
    output logic                  frame_err
`endif
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  par_en_q;   // PAR_EN frozen for the current frame
    logic                  par_flag;   // captured parity error

    logic [PRESCALE_W-1:0] last_edge;
    logic [PRESCALE_W-1:0] pre_chk_edge;
    logic                  at_end;
    logic                  at_pre_chk;
    logic                  last_bit;

    // Strobes are registered, so they are launched one edge early: the
    // register is loaded when edge_cnt == CHK_EDGE-1 and is therefore high
    // while edge_cnt == CHK_EDGE (Prescale/2 + 2).
    assign last_edge    = Prescale - PRESCALE_W'(1);
    assign pre_chk_edge = (Prescale >> 1) + PRESCALE_W'(1);
    assign at_end       = (edge_cnt == last_edge);
    assign at_pre_chk   = (edge_cnt == pre_chk_edge);
    assign last_bit     = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

    // NOTE: all state and outputs live in one clocked block and use
    // non-blocking assignments, so every read sees the pre-edge value and
    // later assignments in the block simply override earlier defaults.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            par_en_q    <= 1'b0;
            par_flag    <= 1'b0;
            dat_samp_en <= 1'b0;
            strt_chk_en <= 1'b0;
            deser_en    <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
`ifdef UART_RX_ERR_OUT_EN
            frame_err   <= 1'b0;
`endif
        end else begin
            // One-cycle pulses default low.
            strt_chk_en <= 1'b0;
            deser_en    <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
`ifdef UART_RX_ERR_OUT_EN
            frame_err   <= 1'b0;
`endif
            if (state == IDLE) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= at_end ? '0 : edge_cnt + PRESCALE_W'(1);
            end

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!RX_IN) begin
                        state       <= START;
                        par_en_q    <= PAR_EN;
                        par_flag    <= 1'b0;
                        dat_samp_en <= 1'b1;
                    end
                end

                START: begin
                    strt_chk_en <= at_pre_chk;
                    if (at_end) begin
                        if (strt_glitch) begin
                            state       <= IDLE;
                            dat_samp_en <= 1'b0;
`ifdef UART_RX_ERR_OUT_EN
                            frame_err   <= 1'b1;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    deser_en <= at_pre_chk;
                    if (at_end) begin
                        if (last_bit) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end

                PARITY: begin
                    par_chk_en <= at_pre_chk;
                    if (at_end) begin
                        par_flag <= par_err;
                        state    <= STOP;
                    end
                end

                STOP: begin
                    stp_chk_en <= at_pre_chk;
                    if (at_end) begin
                        state       <= IDLE;
                        dat_samp_en <= 1'b0;
                        data_valid  <= !stp_err && !par_flag;
`ifdef UART_RX_ERR_OUT_EN
                        frame_err   <= stp_err || par_flag;
`endif
                    end
                end

                default: begin
                    state       <= IDLE;
                    dat_samp_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fsm
//
// Self-checking bench for uart_rx_fsm. A table of frame records (settings
// plus hand-computed strobe cycles) is applied in a loop; each frame is
// watched cycle by cycle and the first/last/count of every strobe is
// compared with the table. Hand-written sequences cover reset, mid-frame
// reset and back-to-back frames. Cycle 0 is the first START cycle.
// ---------------------------------------------------------------------------
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
`ifdef UART_RX_ERR_OUT_EN
    logic       frame_err;
`endif

    uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .dat_samp_en (dat_samp_en),
        .strt_chk_en (strt_chk_en),
        .deser_en    (deser_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid)
`ifdef UART_RX_ERR_OUT_EN
        ,
        .frame_err   (frame_err)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Strobe indices into the recording arrays.
    localparam int S_STRT = 0, S_DESER = 1, S_PAR = 2, S_STP = 3, S_DV = 4, S_FERR = 5;

    int first [6];
    int last  [6];
    int cnt   [6];
    int overlap;
    int samp_hi;
    int samp_off;

    // Watch ncyc cycles starting at cycle 0. Outputs are sampled and inputs
    // driven on the falling edge. RX_IN follows a real serial frame unless
    // forced low from rx_low_from onward.
    task automatic watch(input int ncyc, input int p, input bit pe,
                         input logic [7:0] d, input int glitch_at,
                         input int flip_at, input int rx_low_from);
        logic [5:0] s;
        int         bitpos;
        for (int k = 0; k < 6; k++) begin
            first[k] = -1;
            last[k]  = -1;
            cnt[k]   = 0;
        end
        overlap  = 0;
        samp_hi  = 0;
        samp_off = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge CLK);
            s = {1'b0, data_valid, stp_chk_en, par_chk_en, deser_en, strt_chk_en};
`ifdef UART_RX_ERR_OUT_EN
            s[S_FERR] = frame_err;
`endif
            for (int k = 0; k < 6; k++) begin
                if (s[k]) begin
                    if (first[k] < 0) first[k] = c;
                    last[k] = c;
                    cnt[k]++;
                end
            end
            if ((int'(s[0]) + int'(s[1]) + int'(s[2]) + int'(s[3])) > 1) overlap++;
            if (dat_samp_en) samp_hi++;
            else if (samp_off < 0) samp_off = c;

            bitpos = c / p;
            if (rx_low_from >= 0 && c >= rx_low_from) RX_IN = 1'b0;
            else if (bitpos == 0)                      RX_IN = 1'b0;
            else if (bitpos <= 8)                      RX_IN = d[bitpos-1];
            else if (pe && bitpos == 9)                RX_IN = ^d;
            else                                       RX_IN = 1'b1;
            strt_glitch = (glitch_at >= 0 && c >= glitch_at);
            if (c == flip_at) PAR_EN = ~PAR_EN;
        end
    endtask

    // Drive the start-bit edge; returns right after the edge that enters
    // START, so the next falling edge is mid-cycle 0.
    task automatic start_frame();
        @(negedge CLK);
        RX_IN = 1'b0;
        @(posedge CLK);
    endtask

    task automatic do_reset();
        RST         = 1'b1;
        RX_IN       = 1'b1;
        strt_glitch = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    typedef struct {
        int         p;
        bit         pe;
        logic [7:0] d;
        int         glitch_at;
        bit         perr;
        bit         serr;
        int         flip_at;
        int         strt;
        int         deser_first;
        int         deser_last;
        int         deser_n;
        int         par;
        int         stp;
        int         dv;
        int         ferr;
        int         idle;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //         p  pe  data    glt  pe  se flip strt dF  dL  dN  par  stp  dv   ferr idle
        vecs[0] = '{8,  1'b0, 8'hA5, -1, 1'b0, 1'b0, -1,  6, 14,  70, 8, -1,  78,  80,  -1,  80};
        vecs[1] = '{16, 1'b1, 8'h3C, -1, 1'b0, 1'b0, -1, 10, 26, 138, 8, 154, 170, 176,  -1, 176};
        vecs[2] = '{8,  1'b0, 8'hA5,  7, 1'b0, 1'b0, -1,  6, -1,  -1, 0, -1,  -1,  -1,   8,   8};
        vecs[3] = '{8,  1'b1, 8'h5A, -1, 1'b1, 1'b0, -1,  6, 14,  70, 8, 78,  86,  -1,  88,  88};
        vecs[4] = '{8,  1'b0, 8'hFF, -1, 1'b0, 1'b1, -1,  6, 14,  70, 8, -1,  78,  -1,  80,  80};
        vecs[5] = '{32, 1'b0, 8'h81, -1, 1'b0, 1'b0, -1, 18, 50, 274, 8, -1, 306, 320,  -1, 320};
        vecs[6] = '{8,  1'b1, 8'hC3, -1, 1'b0, 1'b0, -1,  6, 14,  70, 8, 78,  86,  88,  -1,  88};
        vecs[7] = '{8,  1'b0, 8'hA5, -1, 1'b0, 1'b0,  1,  6, 14,  70, 8, -1,  78,  80,  -1,  80};

        RST         = 1'b1;
        RX_IN       = 1'b1;
        Prescale    = 6'd8;
        PAR_EN      = 1'b0;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;

        // Reset state and quiet idle line.
        repeat (2) @(negedge CLK);
        check("reset outputs",
              int'({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid}), 0);
`ifdef UART_RX_ERR_OUT_EN
        check("reset frame_err", int'(frame_err), 0);
`endif
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("idle dat_samp_en", int'(dat_samp_en), 0);

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            Prescale    = 6'(vecs[i].p);
            PAR_EN      = vecs[i].pe;
            par_err     = vecs[i].perr;
            stp_err     = vecs[i].serr;
            strt_glitch = 1'b0;
            start_frame();
            watch(vecs[i].idle + 3, vecs[i].p, vecs[i].pe, vecs[i].d,
                  vecs[i].glitch_at, vecs[i].flip_at, -1);
            check($sformatf("v%0d strt_chk_en cycle", i), first[S_STRT], vecs[i].strt);
            check($sformatf("v%0d deser_en first", i), first[S_DESER], vecs[i].deser_first);
            check($sformatf("v%0d deser_en last", i), last[S_DESER], vecs[i].deser_last);
            check($sformatf("v%0d deser_en count", i), cnt[S_DESER], vecs[i].deser_n);
            check($sformatf("v%0d par_chk_en cycle", i), first[S_PAR], vecs[i].par);
            check($sformatf("v%0d stp_chk_en cycle", i), first[S_STP], vecs[i].stp);
            check($sformatf("v%0d data_valid cycle", i), first[S_DV], vecs[i].dv);
            check($sformatf("v%0d data_valid count", i), cnt[S_DV], (vecs[i].dv >= 0) ? 1 : 0);
            check($sformatf("v%0d dat_samp_en off", i), samp_off, vecs[i].idle);
            check($sformatf("v%0d dat_samp_en cycles", i), samp_hi, vecs[i].idle);
            check($sformatf("v%0d strobe overlap", i), overlap, 0);
`ifdef UART_RX_ERR_OUT_EN
            check($sformatf("v%0d frame_err cycle", i), first[S_FERR], vecs[i].ferr);
            check($sformatf("v%0d frame_err count", i), cnt[S_FERR], (vecs[i].ferr >= 0) ? 1 : 0);
`endif
        end

        // Mid-frame reset at cycle 30 (a deser_en cycle at Prescale=8).
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        par_err  = 1'b0;
        stp_err  = 1'b0;
        start_frame();
        watch(30, 8, 1'b0, 8'hA5, -1, -1, -1);
        @(negedge CLK);
        check("rst deser_en before pulse", int'(deser_en), 1);
        RST   = 1'b1;
        RX_IN = 1'b0;
        #1;
        check("rst outputs same cycle",
              int'({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid}), 0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        watch(12, 8, 1'b0, 8'h00, -1, -1, 0);
        check("rst restart strt_chk_en cycle", first[S_STRT], 6);
        check("rst restart dat_samp_en cycles", samp_hi, 12);
        check("rst restart no data_valid", cnt[S_DV], 0);
        do_reset();

        // Back-to-back frames; RX_IN low from the stop bit onward.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        start_frame();
        watch(170, 8, 1'b0, 8'hA5, -1, -1, 72);
        check("b2b first data_valid", first[S_DV], 80);
        check("b2b second data_valid", last[S_DV], 161);
        check("b2b data_valid count", cnt[S_DV], 2);
        check("b2b deser_en count", cnt[S_DESER], 16);
        check("b2b strt_chk_en count", cnt[S_STRT], 3);
        check("b2b second strt_chk_en", last[S_STRT], 168);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
